// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the in-order RISC-V pipeline.
// Non-memory results pass straight through to write-back. Loads and stores
// are split into single-byte transactions on the byte-wide controller port,
// with a stall request held until the access completes. Load bytes are
// assembled little-endian and sign/zero-extended to 32 bits.
// Optional build macro: MEM_ALIGN_CHECK_EN. When it is defined, misaligned
// half/word accesses are flagged on misalign_o and never reach the bus.
// When it is undefined, misalign_o is tied low and misaligned accesses
// proceed bytewise like aligned ones.

module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [2:0]        alusel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       reg2_i,
    input  logic [2:0]        mem_sel_i,
    input  logic              mem_we_i,
    input  logic              load_sign_i,
    input  logic              stall_i,
    input  logic              mem_gnt_i,
    input  logic [7:0]        mem_rdata_i,
    output logic [4:0]        rd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              stall_req_o,
    output logic              misalign_o
);

    // Result-class code that the execute stage uses to mark loads and stores.
    localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] loadBuf_q, loadBuf_d;
    logic        capValid_q, capValid_d;
    logic [1:0]  capIdx_q, capIdx_d;

    logic        isMemOp;
    logic [1:0]  lastIdx;
    logic        misaligned;
    logic [31:0] loadData;

    // Decode the access: is it a memory op, and which byte index is its last.
    always_comb begin
        isMemOp = (alusel_i == EXE_RES_LOAD_STORE) &&
                  ((mem_sel_i == 3'd1) || (mem_sel_i == 3'd2) || (mem_sel_i == 3'd4));
        case (mem_sel_i)
            3'd2:    lastIdx = 2'd1;
            3'd4:    lastIdx = 2'd3;
            default: lastIdx = 2'd0;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Half accesses need an even address, word accesses a 4-byte-aligned one.
    always_comb begin
        misaligned = isMemOp &&
                     (((mem_sel_i == 3'd2) && mem_addr_i[0]) ||
                      ((mem_sel_i == 3'd4) && (mem_addr_i[1:0] != 2'b00)));
    end
`else
    // Without the check every access is treated as aligned and runs bytewise.
    always_comb begin
        misaligned = 1'b0;
    end
`endif

    // Extend the assembled load using only bytes 0..N-1 so stale upper bytes never leak.
    always_comb begin
        loadData = loadBuf_q;
        case (mem_sel_i)
            3'd1:    loadData = {{24{load_sign_i & loadBuf_q[7]}}, loadBuf_q[7:0]};
            3'd2:    loadData = {{16{load_sign_i & loadBuf_q[15]}}, loadBuf_q[15:0]};
            default: loadData = loadBuf_q;
        endcase
    end

    // Next-state logic: sequence the byte grants and capture read bytes one cycle after each load grant.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loadBuf_d  = loadBuf_q;
        capValid_d = 1'b0;
        capIdx_d   = capIdx_q;

        if (capValid_q) begin
            loadBuf_d[{capIdx_q, 3'b000} +: 8] = mem_rdata_i;
        end

        case (state_q)
            IDLE: begin
                if (isMemOp && !misaligned) begin
                    state_d = ISSUE;
                    cnt_d   = 2'd0;
                end
            end
            ISSUE: begin
                if (mem_gnt_i) begin
                    cnt_d      = cnt_q + 2'd1;
                    capValid_d = !mem_we_i;
                    capIdx_d   = cnt_q;
                    if (cnt_q == lastIdx) begin
                        state_d = mem_we_i ? DONE : DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (!stall_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            loadBuf_q  <= 32'd0;
            capValid_q <= 1'b0;
            capIdx_q   <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            loadBuf_q  <= loadBuf_d;
            capValid_q <= capValid_d;
            capIdx_q   <= capIdx_d;
        end
    end

    // Outputs: pass-through for non-memory ops, bus request while issuing, final result in DONE.
    // While a memory op is still in flight wreg_o is held low so nothing half-finished is written back.
    always_comb begin
        rd_o        = rd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 8'd0;
        stall_req_o = 1'b0;
        misalign_o  = 1'b0;

        if (!rst) begin
            rd_o    = 5'd0;
            wreg_o  = 1'b0;
            wdata_o = 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (isMemOp) begin
                        wreg_o = 1'b0;
                        if (misaligned) begin
                            misalign_o = 1'b1;
                        end else begin
                            stall_req_o = 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    wreg_o      = 1'b0;
                    stall_req_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_we_o    = mem_we_i;
                    mem_addr_o  = mem_addr_i + {{(ADDR_W-2){1'b0}}, cnt_q};
                    mem_wdata_o = reg2_i[{cnt_q, 3'b000} +: 8];
                end
                DRAIN: begin
                    wreg_o      = 1'b0;
                    stall_req_o = 1'b1;
                end
                DONE: begin
                    if (mem_we_i) begin
                        wreg_o  = 1'b0;
                        wdata_o = 32'd0;
                    end else begin
                        wdata_o = loadData;
                    end
                end
                default: begin
                    wreg_o = 1'b0;
                end
            endcase
        end
    end

endmodule
